// File: rtl/sc2bin_stream_array.sv
// sc2bin_stream_array
//   ROW x COL array of signed stochastic-to-binary accumulators. Each cell sums
//   popcount(pos) - popcount(neg) over a run of `len` valid beats. It then applies
//   an arithmetic right shift, an optional ReLU and output saturation in a single
//   cycle. The results drain one row per valid/ready handshake.
//
//   Build option: define SC2BIN_ROUND_EN to round half up before the shift.
//   Without it the shift truncates toward minus infinity.
//
// State table:
//   IDLE  | waiting for start; configuration is latched on start
//   ACCUM | counting valid beats into the accumulators
//   ACT   | one cycle: shift / ReLU / saturate every cell into the output bank
//   DRAIN | presenting output rows, one per handshake
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   clr                   synchronous abort; overrides everything else
//   start, len            begin a run of len valid beats (len 0 runs as 1)
//   relu_en, shft_amt     activation mode and right-shift amount
//   row_mask, col_mask    cell (r,c) is enabled when row_mask[r] & col_mask[c]
//   sc_valid, sc_pos,     stochastic beat input; cell (r,c) uses the slice
//   sc_neg                [SC_W*(r*COL+c) +: SC_W]
//   busy                  high whenever the controller is not in IDLE
//   out_valid, out_ready  row handshake
//   out_data              column k is at [BITWIDTH_OUT*k +: BITWIDTH_OUT]
//   out_row, out_last     index of the presented row; high on the final row
module sc2bin_stream_array #(
    parameter int ROW          = 3,
    parameter int COL          = 32,
    parameter int SC_W         = 2,
    parameter int BITWIDTH_INT = 10,
    parameter int BITWIDTH_OUT = 8,
    parameter int MAX_SHFT     = 4,
    parameter int LEN_W        = 12,
    localparam int SHFT_W      = (MAX_SHFT > 0) ? $clog2(MAX_SHFT + 1) : 1,
    localparam int ROW_W       = (ROW > 1) ? $clog2(ROW) : 1
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         clr,
    input  logic                         start,
    input  logic [LEN_W-1:0]             len,
    input  logic                         relu_en,
    input  logic [SHFT_W-1:0]            shft_amt,
    input  logic [ROW-1:0]               row_mask,
    input  logic [COL-1:0]               col_mask,
    input  logic                         sc_valid,
    input  logic [SC_W*ROW*COL-1:0]      sc_pos,
    input  logic [SC_W*ROW*COL-1:0]      sc_neg,
    output logic                         busy,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [BITWIDTH_OUT*COL-1:0]  out_data,
    output logic [ROW_W-1:0]             out_row,
    output logic                         out_last
);

    // One guard bit above the accumulator holds both acc + delta and the
    // rounded value without overflow.
    localparam int SUM_W = BITWIDTH_INT + 1;

    localparam logic signed [SUM_W-1:0] ACC_MAX  = SUM_W'((2 ** (BITWIDTH_INT - 1)) - 1);
    localparam logic signed [SUM_W-1:0] ACC_MIN  = SUM_W'(-(2 ** (BITWIDTH_INT - 1)));
    localparam logic signed [SUM_W-1:0] OUT_SMAX = SUM_W'((2 ** (BITWIDTH_OUT - 1)) - 1);
    localparam logic signed [SUM_W-1:0] OUT_SMIN = SUM_W'(-(2 ** (BITWIDTH_OUT - 1)));
    localparam logic signed [SUM_W-1:0] OUT_UMAX = SUM_W'((2 ** BITWIDTH_OUT) - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        ACT   = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t                         state;
    logic [LEN_W-1:0]               beat_cnt;
    logic                           relu_q;
    logic [SHFT_W-1:0]              shft_q;
    logic [ROW-1:0]                 row_mask_q;
    logic [COL-1:0]                 col_mask_q;
    logic signed [BITWIDTH_INT-1:0] acc  [ROW][COL];
    logic [BITWIDTH_OUT-1:0]        bank [ROW][COL];

    function automatic logic signed [SUM_W-1:0] cell_delta(
        input logic [SC_W-1:0] p,
        input logic [SC_W-1:0] n
    );
        logic signed [SUM_W-1:0] d;
        d = '0;
        for (int i = 0; i < SC_W; i++) begin
            d = d + $signed({{(SUM_W-1){1'b0}}, p[i]}) - $signed({{(SUM_W-1){1'b0}}, n[i]});
        end
        return d;
    endfunction

    function automatic logic signed [BITWIDTH_INT-1:0] sat_acc(
        input logic signed [SUM_W-1:0] s
    );
        if (s > ACC_MAX) begin
            return ACC_MAX[BITWIDTH_INT-1:0];
        end else if (s < ACC_MIN) begin
            return ACC_MIN[BITWIDTH_INT-1:0];
        end
        return s[BITWIDTH_INT-1:0];
    endfunction

    function automatic logic [BITWIDTH_OUT-1:0] activate(
        input logic signed [BITWIDTH_INT-1:0] a,
        input logic [SHFT_W-1:0]              sh,
        input logic                           relu
    );
        logic signed [SUM_W-1:0] v;
        v = SUM_W'(a);
`ifdef SC2BIN_ROUND_EN
        if (sh != '0) begin
            v = v + (SUM_W'(1) << (sh - SHFT_W'(1)));
        end
`endif
        v = v >>> sh;
        if (relu) begin
            if (v < 0) begin
                return '0;
            end else if (v > OUT_UMAX) begin
                return '1;
            end
        end else begin
            if (v > OUT_SMAX) begin
                return {1'b0, {(BITWIDTH_OUT-1){1'b1}}};
            end else if (v < OUT_SMIN) begin
                return {1'b1, {(BITWIDTH_OUT-1){1'b0}}};
            end
        end
        return v[BITWIDTH_OUT-1:0];
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            beat_cnt   <= '0;
            relu_q     <= 1'b0;
            shft_q     <= '0;
            row_mask_q <= '0;
            col_mask_q <= '0;
            busy       <= 1'b0;
            out_valid  <= 1'b0;
            out_row    <= '0;
            out_last   <= 1'b0;
            for (int r = 0; r < ROW; r++) begin
                for (int c = 0; c < COL; c++) begin
                    acc[r][c]  <= '0;
                    bank[r][c] <= '0;
                end
            end
        end else if (clr) begin
            state     <= IDLE;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            out_row   <= '0;
            out_last  <= 1'b0;
            for (int r = 0; r < ROW; r++) begin
                for (int c = 0; c < COL; c++) begin
                    acc[r][c] <= '0;
                end
            end
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        beat_cnt   <= (len == '0) ? LEN_W'(1) : len;
                        relu_q     <= relu_en;
                        shft_q     <= (shft_amt > SHFT_W'(MAX_SHFT)) ? SHFT_W'(MAX_SHFT) : shft_amt;
                        row_mask_q <= row_mask;
                        col_mask_q <= col_mask;
                        busy       <= 1'b1;
                        state      <= ACCUM;
                        for (int r = 0; r < ROW; r++) begin
                            for (int c = 0; c < COL; c++) begin
                                acc[r][c] <= '0;
                            end
                        end
                    end
                end
                ACCUM: begin
                    if (sc_valid) begin
                        for (int r = 0; r < ROW; r++) begin
                            for (int c = 0; c < COL; c++) begin
                                if (row_mask_q[r] && col_mask_q[c]) begin
                                    acc[r][c] <= sat_acc(SUM_W'(acc[r][c]) +
                                        cell_delta(sc_pos[SC_W*(r*COL+c) +: SC_W],
                                                   sc_neg[SC_W*(r*COL+c) +: SC_W]));
                                end
                            end
                        end
                        if (beat_cnt == LEN_W'(1)) begin
                            state <= ACT;
                        end else begin
                            beat_cnt <= beat_cnt - LEN_W'(1);
                        end
                    end
                end
                ACT: begin
                    for (int r = 0; r < ROW; r++) begin
                        for (int c = 0; c < COL; c++) begin
                            bank[r][c] <= activate(acc[r][c], shft_q, relu_q);
                        end
                    end
                    out_valid <= 1'b1;
                    out_row   <= '0;
                    out_last  <= (ROW == 1);
                    state     <= DRAIN;
                end
                DRAIN: begin
                    if (out_ready) begin
                        if (out_last) begin
                            state     <= IDLE;
                            busy      <= 1'b0;
                            out_valid <= 1'b0;
                            out_row   <= '0;
                            out_last  <= 1'b0;
                        end else begin
                            out_row  <= out_row + ROW_W'(1);
                            // out_row is about to become ROW-1
                            out_last <= (32'(out_row) == ROW - 2);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // The presented row is a plain read of the registered bank, so it stays
    // stable for as long as out_row does.
    always_comb begin
        out_data = '0;
        for (int c = 0; c < COL; c++) begin
            out_data[BITWIDTH_OUT*c +: BITWIDTH_OUT] = bank[out_row][c];
        end
    end

endmodule

// File: tb/tb_sc2bin_stream_array.sv
module tb_sc2bin_stream_array;
    localparam int ROW = 3;
    localparam int COL = 4;
    localparam int SC_W = 2;
    localparam int BI = 10;
    localparam int BO = 8;
    localparam int MAX_SHFT = 4;
    localparam int LEN_W = 12;
    localparam int SHFT_W = 3;
    localparam int ROW_W = 2;
    localparam int PW = SC_W*ROW*COL;
    localparam int DW = BO*COL;

    logic clk = 0;
    logic reset_n = 0;
    logic clr = 0, start = 0, relu_en = 0, sc_valid = 0, out_ready = 0;
    logic [LEN_W-1:0] len = '0;
    logic [SHFT_W-1:0] shft_amt = '0;
    logic [ROW-1:0] row_mask = '0;
    logic [COL-1:0] col_mask = '0;
    logic [PW-1:0] sc_pos = '0, sc_neg = '0;
    logic busy, out_valid, out_last;
    logic [DW-1:0] out_data;
    logic [ROW_W-1:0] out_row;

    sc2bin_stream_array #(.ROW(ROW), .COL(COL), .SC_W(SC_W), .BITWIDTH_INT(BI),
        .BITWIDTH_OUT(BO), .MAX_SHFT(MAX_SHFT), .LEN_W(LEN_W)) dut (
        .clk(clk), .reset_n(reset_n), .clr(clr), .start(start), .len(len),
        .relu_en(relu_en), .shft_amt(shft_amt), .row_mask(row_mask), .col_mask(col_mask),
        .sc_valid(sc_valid), .sc_pos(sc_pos), .sc_neg(sc_neg), .busy(busy),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_row(out_row), .out_last(out_last));

    always #5 clk = ~clk;

    int vec_cnt = 0;
    int err_cnt = 0;

    // reference model: plain integers per cell
    int macc [ROW][COL];
    int cfg_shft;
    bit cfg_relu;
    logic [ROW-1:0] cfg_rm;
    logic [COL-1:0] cfg_cm;

    logic [DW-1:0] got_data [ROW];
    int got_row [ROW];
    bit got_last [ROW];
    bit got_ok;

    function automatic int act(int a, int sh_in, bit relu);
        int v;
        int sh;
        sh = (sh_in > MAX_SHFT) ? MAX_SHFT : sh_in;
        v = a;
`ifdef SC2BIN_ROUND_EN
        if (sh > 0) v = v + (1 << (sh - 1));
`endif
        v = v >>> sh;
        if (relu) begin
            if (v < 0) v = 0;
            else if (v > (1 << BO) - 1) v = (1 << BO) - 1;
        end else begin
            if (v > (1 << (BO-1)) - 1) v = (1 << (BO-1)) - 1;
            else if (v < -(1 << (BO-1))) v = -(1 << (BO-1));
        end
        return v;
    endfunction

    function automatic logic [DW-1:0] exp_row(int r);
        logic [DW-1:0] e;
        logic [BO-1:0] t;
        e = '0;
        for (int c = 0; c < COL; c++) begin
            t = BO'(act(macc[r][c], cfg_shft, cfg_relu));
            e[BO*c +: BO] = t;
        end
        return e;
    endfunction

    task automatic model_beat(input logic [PW-1:0] p, input logic [PW-1:0] n);
        for (int r = 0; r < ROW; r++)
            for (int c = 0; c < COL; c++)
                if (cfg_rm[r] && cfg_cm[c]) begin
                    int d;
                    int base;
                    base = SC_W*(r*COL+c);
                    d = 0;
                    for (int b = 0; b < SC_W; b++) d = d + int'(p[base+b]) - int'(n[base+b]);
                    macc[r][c] = macc[r][c] + d;
                    if (macc[r][c] > (1 << (BI-1)) - 1) macc[r][c] = (1 << (BI-1)) - 1;
                    if (macc[r][c] < -(1 << (BI-1))) macc[r][c] = -(1 << (BI-1));
                end
    endtask

    // called at posedge+1 with the DUT idle; leaves the DUT in ACCUM
    task automatic start_run(input int l, input bit relu, input int sh,
                             input logic [ROW-1:0] rm, input logic [COL-1:0] cm);
        start = 1; len = LEN_W'(l); relu_en = relu; shft_amt = SHFT_W'(sh);
        row_mask = rm; col_mask = cm;
        cfg_relu = relu; cfg_shft = sh; cfg_rm = rm; cfg_cm = cm;
        for (int r = 0; r < ROW; r++) for (int c = 0; c < COL; c++) macc[r][c] = 0;
        @(posedge clk); #1;
        start = 0;
        // configuration inputs are scrambled: only the values at start count
        len = LEN_W'($urandom); relu_en = 1'($urandom); shft_amt = SHFT_W'($urandom);
        row_mask = ROW'($urandom); col_mask = COL'($urandom);
    endtask

    task automatic drive_beats(input int n, input int gap_pct, input bit rnd,
                               input logic [PW-1:0] fp, input logic [PW-1:0] fn);
        for (int i = 0; i < n; i++) begin
            while (int'($urandom_range(99)) < gap_pct) begin
                sc_valid = 0; sc_pos = PW'($urandom); sc_neg = PW'($urandom);
                start = 1'($urandom);
                @(posedge clk); #1;
            end
            sc_valid = 1;
            sc_pos = rnd ? PW'($urandom) : fp;
            sc_neg = rnd ? PW'($urandom) : fn;
            start = rnd ? 1'($urandom) : 1'b0;
            model_beat(sc_pos, sc_neg);
            @(posedge clk); #1;
        end
        sc_valid = 0; start = 0;
    endtask

    task automatic collect();
        got_ok = 1;
        for (int r = 0; r < ROW; r++) begin
            int t;
            t = 0;
            while (out_valid !== 1'b1 && t < 50) begin @(posedge clk); #1; t++; end
            if (out_valid !== 1'b1) begin got_ok = 0; break; end
            got_data[r] = out_data; got_row[r] = int'(out_row); got_last[r] = out_last;
            out_ready = 1;
            @(posedge clk); #1;
            out_ready = 0;
        end
    endtask

    task automatic test_reset();
        #2;
        vec_cnt++;
        if (busy !== 0 || out_valid !== 0 || out_row !== 0 || out_last !== 0 || out_data !== '0) begin
            err_cnt++;
            $display("FAIL reset: busy=%b valid=%b row=%0d last=%b data=%h, expected all zero",
                     busy, out_valid, out_row, out_last, out_data);
        end
        #20 reset_n = 1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        logic [PW-1:0] fp;
        fp = '0; fp[1:0] = 2'b11;
        start_run(4, 1, 1, '1, '1);
        drive_beats(4, 0, 0, fp, '0);
        vec_cnt++;
        if (out_valid !== 0 || busy !== 1) begin
            err_cnt++; $display("FAIL basic_latency_act: valid=%b busy=%b, expected 0 1", out_valid, busy);
        end
        @(posedge clk); #1;
        vec_cnt++;
        if (out_valid !== 1) begin
            err_cnt++; $display("FAIL basic_latency: valid=%b, expected 1", out_valid);
        end
        collect();
        vec_cnt++;
        if (!got_ok) begin err_cnt++; $display("FAIL basic_timeout: got no row, expected %0d rows", ROW); end
        vec_cnt++;
        if (got_data[0][7:0] !== 8'd4 || got_data[0][15:8] !== 8'd0) begin
            err_cnt++; $display("FAIL basic_cell00: got %h, expected 04 at col0, 00 at col1", got_data[0][15:0]);
        end
        for (int r = 0; r < ROW; r++) begin
            vec_cnt++;
            if (got_data[r] !== exp_row(r) || got_row[r] != r || got_last[r] != (r == ROW-1)) begin
                err_cnt++;
                $display("FAIL basic_row%0d: data=%h row=%0d last=%0d, expected data=%h row=%0d last=%0d",
                         r, got_data[r], got_row[r], got_last[r], exp_row(r), r, r == ROW-1);
            end
        end
        vec_cnt++;
        if (out_valid !== 0 || busy !== 0) begin
            err_cnt++; $display("FAIL basic_end: valid=%b busy=%b, expected 0 0", out_valid, busy);
        end
    endtask

    task automatic test_negative();
        logic [PW-1:0] fn;
        fn = '0; fn[1:0] = 2'b11;
        for (int m = 0; m < 2; m++) begin
            start_run(4, m == 0, 0, '1, '1);
            drive_beats(4, 0, 0, '0, fn);
            collect();
            vec_cnt++;
            if (!got_ok || got_data[0][7:0] !== ((m == 0) ? 8'h00 : 8'hF8)) begin
                err_cnt++;
                $display("FAIL negative_m%0d: ok=%b cell00=%h, expected %h", m, got_ok, got_data[0][7:0],
                         (m == 0) ? 8'h00 : 8'hF8);
            end
        end
    endtask

    task automatic test_saturation();
        for (int m = 0; m < 3; m++) begin
            start_run(300, m == 0, 0, '1, '1);
            drive_beats(300, 0, 0, (m == 2) ? '0 : '1, (m == 2) ? '1 : '0);
            collect();
            vec_cnt++;
            if (!got_ok || got_data[ROW-1] !== {COL{(m == 0) ? 8'hFF : (m == 1) ? 8'h7F : 8'h80}}) begin
                err_cnt++;
                $display("FAIL saturation_m%0d: ok=%b last row=%h", m, got_ok, got_data[ROW-1]);
            end
            for (int r = 0; r < ROW; r++) begin
                vec_cnt++;
                if (got_data[r] !== exp_row(r)) begin
                    err_cnt++; $display("FAIL saturation_m%0d_row%0d: got %h, expected %h", m, r, got_data[r], exp_row(r));
                end
            end
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 8; it++) begin
            int l;
            l = (it == 0) ? 0 : int'($urandom_range(1, 40));
            start_run(l, 1'($urandom), int'($urandom_range(0, 7)), '1, '1);
            drive_beats((l == 0) ? 1 : l, 20, 1, '0, '0);
            collect();
            vec_cnt++;
            if (!got_ok) begin err_cnt++; $display("FAIL random%0d_timeout: no rows, expected %0d", it, ROW); end
            for (int r = 0; r < ROW; r++) begin
                vec_cnt++;
                if (got_data[r] !== exp_row(r) || got_row[r] != r || got_last[r] != (r == ROW-1)) begin
                    err_cnt++;
                    $display("FAIL random%0d_row%0d: data=%h row=%0d last=%0d, expected data=%h row=%0d last=%0d",
                             it, r, got_data[r], got_row[r], got_last[r], exp_row(r), r, r == ROW-1);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int t;
        start_run(10, 0, 1, '1, '1);
        drive_beats(10, 40, 1, '0, '0);
        t = 0;
        while (out_valid !== 1'b1 && t < 50) begin @(posedge clk); #1; t++; end
        for (int k = 0; k < 5; k++) begin
            vec_cnt++;
            if (out_valid !== 1 || out_data !== exp_row(0) || out_row !== 0) begin
                err_cnt++;
                $display("FAIL hold%0d: valid=%b data=%h row=%0d, expected 1 %h 0", k, out_valid, out_data, out_row, exp_row(0));
            end
            @(posedge clk); #1;
        end
        collect();
        for (int r = 0; r < ROW; r++) begin
            vec_cnt++;
            if (!got_ok || got_data[r] !== exp_row(r) || got_row[r] != r) begin
                err_cnt++;
                $display("FAIL backpressure_row%0d: ok=%b data=%h row=%0d, expected %h %0d", r, got_ok, got_data[r], got_row[r], exp_row(r), r);
            end
        end
    endtask

    task automatic test_mask();
        for (int m = 0; m < 3; m++) begin
            logic [ROW-1:0] rm;
            logic [COL-1:0] cm;
            rm = (m == 0) ? ROW'(1) : ROW'($urandom);
            cm = (m == 0) ? COL'(2) : COL'($urandom);
            start_run(6, 1, 0, rm, cm);
            drive_beats(6, 10, m != 0, '1, '0);
            collect();
            if (m == 0) begin
                vec_cnt++;
                if (got_data[0] !== 32'h0000_0C00 || got_data[1] !== '0 || got_data[2] !== '0) begin
                    err_cnt++;
                    $display("FAIL mask_single: rows=%h %h %h, expected 00000c00 0 0", got_data[0], got_data[1], got_data[2]);
                end
            end
            for (int r = 0; r < ROW; r++) begin
                vec_cnt++;
                if (!got_ok || got_data[r] !== exp_row(r)) begin
                    err_cnt++; $display("FAIL mask%0d_row%0d: got %h, expected %h", m, r, got_data[r], exp_row(r));
                end
            end
        end
    endtask

    task automatic test_clr();
        int t;
        start_run(8, 0, 0, '1, '1);
        sc_valid = 1; sc_pos = PW'($urandom); sc_neg = PW'($urandom);
        @(posedge clk); #1;
        clr = 1; start = 1; len = 5;
        @(posedge clk); #1;
        vec_cnt++;
        if (busy !== 0 || out_valid !== 0) begin
            err_cnt++; $display("FAIL clr_accum: busy=%b valid=%b, expected 0 0", busy, out_valid);
        end
        clr = 0; start = 0; sc_valid = 0;
        @(posedge clk); #1;
        vec_cnt++;
        if (busy !== 0) begin err_cnt++; $display("FAIL clr_start_ignored: busy=%b, expected 0", busy); end
        start_run(5, 0, 2, '1, '1);
        drive_beats(5, 0, 1, '0, '0);
        collect();
        for (int r = 0; r < ROW; r++) begin
            vec_cnt++;
            if (!got_ok || got_data[r] !== exp_row(r)) begin
                err_cnt++; $display("FAIL clr_fresh_row%0d: got %h, expected %h", r, got_data[r], exp_row(r));
            end
        end
        start_run(3, 0, 0, '1, '1);
        drive_beats(3, 0, 1, '0, '0);
        t = 0;
        while (out_valid !== 1'b1 && t < 50) begin @(posedge clk); #1; t++; end
        out_ready = 1; @(posedge clk); #1; out_ready = 0;
        clr = 1; @(posedge clk); #1; clr = 0;
        vec_cnt++;
        if (out_valid !== 0 || busy !== 0 || out_row !== 0) begin
            err_cnt++; $display("FAIL clr_drain: valid=%b busy=%b row=%0d, expected 0 0 0", out_valid, busy, out_row);
        end
    endtask

    task automatic test_rounding();
        logic [PW-1:0] a, b;
        logic [7:0] e;
        a = '0; a[1:0] = 2'b11;
        b = '0; b[1:0] = 2'b01;
        for (int m = 0; m < 2; m++) begin
            start_run(3, 0, 1, '1, '1);
            if (m == 0) begin drive_beats(2, 0, 0, a, '0); drive_beats(1, 0, 0, b, '0); end
            else begin drive_beats(2, 0, 0, '0, a); drive_beats(1, 0, 0, '0, b); end
`ifdef SC2BIN_ROUND_EN
            e = (m == 0) ? 8'd3 : 8'hFE;
`else
            e = (m == 0) ? 8'd2 : 8'hFD;
`endif
            collect();
            vec_cnt++;
            if (!got_ok || got_data[0][7:0] !== e || got_data[0] !== exp_row(0)) begin
                err_cnt++; $display("FAIL round_m%0d: cell00=%h, expected %h", m, got_data[0][7:0], e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_negative();
        test_saturation();
        test_random();
        test_back_to_back();
        test_mask();
        test_clr();
        test_rounding();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
